sci_tx: RTL

//  8N1 asynchronous serial transmitter: the TX half of the SCI link, the partner to the SCI receiver.

---
 rtl/sci_tx_pkg.sv | 12 +
 rtl/sci_tx_if.sv | 15 +
 rtl/sci_tx_fifo.sv | 54 +++++
 rtl/sci_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sci_tx_pkg.sv
// Shared SCI definitions: oversample ratio, byte width and transmitter FSM encodings.
package sci_tx_pkg;
   localparam int SCI_OVS       = 7;
   localparam int SCI_DATA_BITS = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   typedef logic [SCI_DATA_BITS-1:0] sci_byte_t;
endpackage

// File: rtl/sci_tx_if.sv
// Byte-queue side of the SCI transmitter: write strobe, data and FIFO status.
interface sci_tx_if;
   import sci_tx_pkg::*;

   sci_byte_t tx_data;
   logic      tx_wr;
   logic      tx_full;
   logic      tx_empty;
   logic      tx_ovf;

   modport master (output tx_data, output tx_wr,
                   input  tx_full, input tx_empty, input tx_ovf);
   modport slave  (input  tx_data, input tx_wr,
                   output tx_full, output tx_empty, output tx_ovf);
endinterface

// File: rtl/sci_tx_fifo.sv
// Small synchronous write FIFO with show-ahead output; flags decode from the registered count.
module sci_tx_fifo
   import sci_tx_pkg::*;
#(
   parameter int FIFO_AW = 2
) (
   input  logic      baud_clk,
   input  logic      rst_n,
   input  logic      wr,
   input  sci_byte_t din,
   input  logic      rd,
   output sci_byte_t dout,
   output logic      full,
   output logic      empty,
   output logic      ovf
);
   localparam int DEPTH = 2 ** FIFO_AW;

   sci_byte_t            mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic [FIFO_AW:0]     count;
   logic                 wr_ok;
   logic                 rd_ok;

   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign empty = (count == '0);
   // A write while full is refused even if the same cycle pops a byte.
   assign wr_ok = wr & ~full;
   assign rd_ok = rd & ~empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge baud_clk) begin
      if (wr_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         ovf <= wr & full;
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sci_tx.sv
// 8N1 serial transmitter: FIFO-fed shifter, LSB first, back-to-back frames while bytes are queued.
module sci_tx
   import sci_tx_pkg::*;
#(
   parameter int OVS       = SCI_OVS,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW   = 2
) (
   input  logic     baud_clk,
   input  logic     rst_n,
   sci_tx_if.slave  bus,
   output logic     txd,
   output logic     tx_busy,
   output logic     tx_done
);
   localparam int STOP_LEN = STOP_BITS * OVS;
   localparam int SW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;

   logic [1:0]    state, state_n;
   logic [3:0]    tick, tick_n;
   logic [2:0]    bitc, bitc_n;
   logic [SW-1:0] stop_cnt, stop_cnt_n;
   sci_byte_t     sh, sh_n;
   sci_byte_t     head;
   logic          pop;
   logic          tick_last;
   logic          stop_last;
   logic          fifo_empty;

   sci_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .baud_clk (baud_clk),
      .rst_n    (rst_n),
      .wr       (bus.tx_wr),
      .din      (bus.tx_data),
      .rd       (pop),
      .dout     (head),
      .full     (bus.tx_full),
      .empty    (fifo_empty),
      .ovf      (bus.tx_ovf)
   );

   assign bus.tx_empty = fifo_empty;
   assign tick_last    = (tick == 4'(OVS - 1));
   assign stop_last    = (stop_cnt == SW'(STOP_LEN - 1));
   assign tx_busy      = (state != S_IDLE);

   always_comb begin
      state_n    = state;
      tick_n     = tick;
      bitc_n     = bitc;
      stop_cnt_n = stop_cnt;
      sh_n       = sh;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_n    = head;
               bitc_n  = '0;
               tick_n  = '0;
               state_n = S_START;
            end
         end
         S_START: begin
            tick_n = tick + 1'b1;
            if (tick_last) begin
               tick_n  = '0;
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            tick_n = tick + 1'b1;
            if (tick_last) begin
               tick_n = '0;
               sh_n   = sh >> 1;
               bitc_n = bitc + 1'b1;
               if (bitc == 3'd7) begin
                  stop_cnt_n = '0;
                  state_n    = S_STOP;
               end
            end
         end
         default: begin
            stop_cnt_n = stop_cnt + 1'b1;
            if (stop_last) begin
               // Chain straight into the next start bit so queued frames have no idle gap.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  sh_n    = head;
                  bitc_n  = '0;
                  tick_n  = '0;
                  state_n = S_START;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         tick     <= '0;
         bitc     <= '0;
         stop_cnt <= '0;
         sh       <= '0;
         txd      <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         tick     <= tick_n;
         bitc     <= bitc_n;
         stop_cnt <= stop_cnt_n;
         sh       <= sh_n;
         // Line level and done strobe follow the state one cycle later, so both stay aligned.
         txd      <= (state == S_START) ? 1'b0 : (state == S_DATA) ? sh[0] : 1'b1;
         tx_done  <= (state == S_STOP) && stop_last;
      end
   end
endmodule
